// File: rtl/motor_pkg.sv
// Shared encodings for the motor scheduler: FSM states, direction
// polarity and command-word field positions.
package motor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEAD_WAIT,
    HOME,
    MOVE,
    RELEASE
  } state_t;

  localparam logic DIR_HOME = 1'b1;
  localparam logic DIR_OUT  = 1'b0;

  localparam int unsigned CH_LSB    = 8;
  localparam int unsigned ANG_MSB   = 7;
  localparam int unsigned TGT_SHIFT = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping) wins; one-hot grant plus encoded index.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/motor_sched.sv
// Time-shares one motor driver among NCH channels: homes each channel on its
// limit switch, then steps it to the commanded target, one motor at a time.
module motor_sched
  import motor_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned POSW     = 11,
  parameter int unsigned HOME_MAX = 2400,
  parameter int unsigned DEAD     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_tick,
  input  logic             WR,
  input  logic [15:0]      byte_data_received,
  input  logic [NCH-1:0]   home_sw,
  output logic [NCH-1:0]   M_EN,
  output logic             DIR,
  output logic             busy,
  output logic [1:0]       active_ch,
  output logic [NCH-1:0]   homed,
  output logic [NCH-1:0]   fault
);

  localparam int unsigned DCW = $clog2(DEAD + 1);
  localparam int unsigned HCW = $clog2(HOME_MAX + 1);

  state_t          state;
  logic [POSW-1:0] tgt [NCH];
  logic [POSW-1:0] pos [NCH];
  logic [1:0]      ptr;
  logic [DCW-1:0]  dead_cnt;
  logic [HCW-1:0]  home_cnt;

  logic [NCH-1:0]  pending;
  logic [NCH-1:0]  unused_grant;
  logic [1:0]      gnt_idx;
  logic            gnt_any;

  logic [1:0]      wr_ch;
  logic [POSW-1:0] wr_tgt;
  logic            unused_hi;
  logic [POSW-1:0] cur_pos;
  logic [POSW-1:0] cur_tgt;
  logic            need_dir;
  logic [NCH-1:0]  ch_onehot;

  assign wr_ch     = byte_data_received[CH_LSB+1:CH_LSB];
  assign wr_tgt    = POSW'(byte_data_received[ANG_MSB:0]) << TGT_SHIFT;
  assign unused_hi = ^byte_data_received[15:CH_LSB+2];
  assign cur_pos   = pos[active_ch];
  assign cur_tgt   = tgt[active_ch];
  assign need_dir  = (cur_pos > cur_tgt) ? DIR_HOME : DIR_OUT;
  assign ch_onehot = {{(NCH-1){1'b0}}, 1'b1} << active_ch;

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < NCH; i++)
      pending[i] = !fault[i] && (!homed[i] || (pos[i] != tgt[i]));
  end

  rr_arbiter #(.N(NCH), .IW(2)) u_arb (
    .req   (pending),
    .ptr   (ptr),
    .grant (unused_grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) tgt[i] <= '0;
    end else if (WR && (32'(wr_ch) < NCH)) begin
      tgt[wr_ch] <= wr_tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      M_EN      <= '0;
      DIR       <= DIR_HOME;
      busy      <= 1'b0;
      active_ch <= '0;
      homed     <= '0;
      fault     <= '0;
      ptr       <= '0;
      dead_cnt  <= '0;
      home_cnt  <= '0;
      for (int unsigned i = 0; i < NCH; i++) pos[i] <= '0;
    end else begin
      // Enable follows the state one clock late, so it never overlaps a dead gap.
      M_EN <= (state == HOME || state == MOVE) ? ch_onehot : '0;
      case (state)
        IDLE: if (gnt_any) begin
          active_ch <= gnt_idx;
          busy      <= 1'b1;
          dead_cnt  <= '0;
          state     <= DEAD_WAIT;
        end
        DEAD_WAIT: if (step_tick) begin
          if (dead_cnt == DCW'(DEAD - 1)) begin
            dead_cnt <= '0;
            home_cnt <= '0;
            if (!homed[active_ch]) begin
              DIR   <= DIR_HOME;
              state <= HOME;
            end else begin
              DIR   <= need_dir;
              state <= MOVE;
            end
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        HOME: if (step_tick) begin
          if (!home_sw[active_ch]) begin
            pos[active_ch]   <= '0;
            homed[active_ch] <= 1'b1;
            state            <= DEAD_WAIT;
          end else if (home_cnt == HCW'(HOME_MAX - 1)) begin
            fault[active_ch] <= 1'b1;
            homed[active_ch] <= 1'b0;
            state            <= RELEASE;
          end else begin
            home_cnt <= home_cnt + 1'b1;
          end
        end
        MOVE: if (step_tick) begin
          if (cur_pos == cur_tgt)
            state <= RELEASE;
          else if (need_dir != DIR)
            state <= DEAD_WAIT;
          else if (DIR == DIR_OUT) begin
            if (cur_pos != '1) pos[active_ch] <= cur_pos + 1'b1;
          end else if (cur_pos != '0) begin
            pos[active_ch] <= cur_pos - 1'b1;
          end
        end
        RELEASE: begin
          ptr   <= (32'(active_ch) == NCH - 1) ? 2'd0 : active_ch + 2'd1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A new command clears a homing fault, even one raised this same cycle.
      if (WR && (32'(wr_ch) < NCH)) fault[wr_ch] <= 1'b0;
    end
  end

endmodule

// File: doc/motor_sched.md
Name: motor_sched

Overview:
- Shares one motor power/driver budget among NCH positioning channels (blinds/vents); exactly one motor runs at any time.
- Takes target commands from the UART command word, homes each channel against its active-low limit switch, then steps it to its target on a slow step tick.
- Sits between the UART receiver and the per-channel motor drivers. Drives per-channel enables and one shared direction line.

Parameters:
- NCH, 4, number of channels (power of 2, ≤ 4; channel field is 2 bits).
- POSW, 11, position/target width in steps.
- HOME_MAX, 2400, homing step limit before fault.
- DEAD, 2, step ticks with all enables low before granting a channel or reversing direction.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- step_tick  in  1  one-clk pulse, motor step rate.
- WR  in  1  one-clk pulse, byte_data_received valid.
- byte_data_received  in  16  [9:8] channel, [7:0] angle; target = angle<<3.
- home_sw  in  NCH  per-channel limit switch, 0 = at home (pre-synchronised).
- M_EN  out  NCH  per-channel motor enable, one-hot or zero.
- DIR  out  1  shared direction, 1 = toward home, 0 = away.
- busy  out  1  FSM not in IDLE.
- active_ch  out  2  currently granted channel.
- homed  out  NCH  channel has a valid position.
- fault  out  NCH  homing timed out.

Behaviour:
- Reset (async): M_EN=0, DIR=1, busy=0, active_ch=0, homed=0, fault=0. All targets and positions = 0. RR pointer = 0. State = IDLE. Reset mid-move drops enables immediately.
- WR: in the cycle after the pulse, tgt[ch] = {angle,3'b000} zero-extended to POSW bits. A WR also clears fault[ch].
- Channel ch is pending when !fault[ch] && (!homed[ch] || pos[ch]!=tgt[ch]).
- Arbitration: round-robin starting from the pointer. After RELEASE the pointer moves to active_ch+1 mod NCH. Decided in IDLE only; there is no preemption.
- FSM states:
  - IDLE: if any channel is pending, latch active_ch and go to DEAD_WAIT.
  - DEAD_WAIT: M_EN=0. Count DEAD step_ticks. Set DIR=1 if !homed[active_ch], else DIR = (pos>tgt). Then go to HOME or MOVE. DIR changes only in this state.
  - HOME: M_EN[active_ch]=1, DIR=1. On each step_tick:
    - home_sw[active_ch]==0: pos=0, homed=1, go to DEAD_WAIT.
    - otherwise: increment the step counter; when it reaches HOME_MAX, set fault=1, homed=0, go to RELEASE.
  - MOVE: M_EN[active_ch]=1. On each step_tick:
    - pos==tgt: go to RELEASE.
    - the direction needed by the current tgt differs from DIR (retarget mid-move): go to DEAD_WAIT without stepping.
    - otherwise pos += 1 (DIR=0) or pos -= 1 (DIR=1).
  - RELEASE: M_EN=0, advance the pointer, go to IDLE. Lasts one clk.
- Outputs are registered. M_EN asserts one clk after entering HOME/MOVE and deasserts one clk after leaving them.
- WR and step_tick in the same clk: the step compares against the old target; the new target applies from the next tick.
- WR to a channel that is not active never disturbs the active move.
- pos saturates: it never steps below 0 or above 2^POSW-1.
- home_sw of non-active channels is ignored.
- Retarget to the current position during MOVE: release on the next tick.

Decomposition:
- motor_pkg:
  - state encoding (IDLE, DEAD_WAIT, HOME, MOVE, RELEASE);
  - DIR_HOME=1, DIR_OUT=0;
  - command field positions (CH_LSB=8, ANG_MSB=7);
  - TGT_SHIFT=3.
- Sub-module rr_arbiter: NCH request vector plus pointer in, one-hot grant and encoded index out, combinational. Reused by future shared-resource blocks.

Test Plan:
- WR ch0 angle=4 (tgt 32), home_sw[0]=1 for 10 ticks then 0:
  - DEAD_WAIT 2 ticks;
  - HOME with M_EN=0001, DIR=1 for 10 ticks;
  - homed[0]=1 and pos=0;
  - DEAD_WAIT 2 ticks;
  - MOVE with DIR=0 for 32 ticks, pos=32;
  - M_EN=0, busy=0.
- All channels homed at pos 0; WR ch1 tgt 16 and ch3 tgt 8 in consecutive clks → ch1 fully served first, then ch3. M_EN is never multi-hot; there are DEAD ticks between them.
- Homing with home_sw held 1 → after 2400 ticks fault[0]=1, M_EN=0, ch0 skipped. A new WR ch0 clears the fault and retries homing.
- Mid-move retarget: ch2 at pos 40 heading to 80, WR ch2 angle=2 (tgt 16) →
  - M_EN drops;
  - DEAD ticks;
  - DIR=1;
  - pos decrements to 16, then release.
- WR coinciding with step_tick on the active channel → that tick uses the old target; the next tick uses the new one.
- Assert rst during MOVE → M_EN=0 the same cycle (async); homed=0; after release, pending channels home again.
